rx_responder: RTL and testbench

RX_RESPONDER -- requirements
Module: rx_responder

---
 rtl/rx_pkg.sv | 16 +
 rtl/rx_responder_if.sv | 29 ++
 rtl/rx_fifo.sv | 80 ++++++++
 rtl/rx_responder.sv | 110 +++++++++++
 tb/tb_rx_responder.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared types for the receive responder.
// DATA_W      : payload width in bits.
// data_t      : a payload word.
// chk_state_t : states of the transmitter protocol checker.
package rx_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } chk_state_t;

endpackage : rx_pkg

// File: rtl/rx_responder_if.sv
// Valid/ready handshake between a transmitter and the responder.
// data  : payload from the transmitter.
// valid : the transmitter has meaningful data.
// stall : backpressure injection that forces ready low.
// ready : the responder accepts data this cycle.
// The master modport is the transmitter side and the slave modport is the responder side.
interface rx_responder_if;
    import rx_pkg::*;

    data_t data;
    logic  valid;
    logic  stall;
    logic  ready;

    modport master (
        output data,
        output valid,
        output stall,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  stall,
        output ready
    );

endinterface : rx_responder_if

// File: rtl/rx_fifo.sv
// Show-ahead FIFO that stores the entries the responder accepts.
// clk, rst : clock and synchronous active-high reset.
// push     : write din at the tail. A push is ignored when the FIFO is full.
// pop      : remove the head entry. A pop is ignored when the FIFO is empty.
// din      : write data.
// dout     : head entry. It reads as zero when the FIFO is empty.
// count    : occupancy, from 0 to DEPTH.
// full     : the FIFO is full.
// empty    : the FIFO is empty.
module rx_fifo
    import rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  data_t                  din,
    output data_t                  dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    data_t mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    // A pop is only honoured against an entry that is already valid. A push into an
    // empty FIFO in the same cycle does not count as a valid head.
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap by natural overflow.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage array has no reset. Entries are invalidated by clearing the pointers.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule : rx_fifo

// File: rtl/rx_responder.sv
// Receive responder. It accepts valid/ready transfers into a show-ahead FIFO, counts
// accepted transfers, and flags transmitters that withdraw or change data while
// backpressured.
// clk, rst  : clock and synchronous active-high reset.
// rx        : handshake interface (data, valid, stall, ready).
// pop       : the consumer removes the head entry.
// out_data  : FIFO head.
// out_valid : the FIFO is not empty.
// count     : FIFO occupancy.
// rx_total  : accepted transfers, modulo 2^CNT_W.
// proto_err : sticky protocol-violation flag. It is cleared only by rst.
module rx_responder
    import rx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    rx_responder_if.slave          rx,
    input  logic                   pop,
    output data_t                  out_data,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       rx_total,
    output logic                   proto_err
);

    logic       fifo_full;
    logic       fifo_empty;
    logic       ready_c;
    logic       xfer;

    logic [CNT_W-1:0] rx_total_q, rx_total_d;
    chk_state_t       state_q, state_d;
    data_t            held_q, held_d;
    logic             err_q, err_d;

    // ready depends only on the current occupancy. A pop in the same cycle does not
    // free a slot until the next cycle.
    assign ready_c  = !rst && !rx.stall && !fifo_full;
    assign rx.ready = ready_c;
    assign xfer     = rx.valid && ready_c;

    rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer),
        .pop   (pop),
        .din   (rx.data),
        .dout  (out_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;

    assign rx_total_d = rx_total_q + CNT_W'(xfer);

    // Protocol checker. Once valid is seen without ready, the transmitter must hold
    // the same data until the transfer completes.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (rx.valid && !ready_c) begin
                    state_d = HOLD;
                    held_d  = rx.data;
                end
            end
            HOLD: begin
                if (xfer) begin
                    state_d = IDLE;
                end else if (rx.valid && (rx.data == held_q)) begin
                    state_d = HOLD;
                end else begin
                    // valid was withdrawn, or data changed while ready was low.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_total_q <= '0;
            state_q    <= IDLE;
            held_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            rx_total_q <= rx_total_d;
            state_q    <= state_d;
            held_q     <= held_d;
            err_q      <= err_d;
        end
    end

    assign rx_total  = rx_total_q;
    assign proto_err = err_q;

endmodule : rx_responder

// File: tb/tb_rx_responder.sv
module tb_rx_responder;
    import rx_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   rst;
    logic                   pop;
    data_t                  out_data;
    logic                   out_valid;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       rx_total;
    logic                   proto_err;

    rx_responder_if tif ();

    rx_responder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (tif.slave),
        .pop       (pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count     (count),
        .rx_total  (rx_total),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    data_t q[$];
    int    m_total;
    bit    m_err;
    bit    m_hold;
    data_t m_held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; tif.valid = 1'b1; tif.data = 8'hEE; tif.stall = 1'b0; pop = 1'b1;
        #1;
        chk("ready_in_rst", {31'd0, tif.ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_rx_total", 32'(rx_total), 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        rst = 1'b0; tif.valid = 1'b0; pop = 1'b0;
        q.delete(); m_total = 0; m_err = 0; m_hold = 0; m_held = '0;
        $display("reset applied");
    endtask

    // One clock cycle: drive inputs, check the pre-edge outputs, advance the model, then check the post-edge state.
    task automatic cycle(input logic v, input data_t d, input logic s, input logic p);
        bit exp_ready, push, popeff;
        tif.valid = v; tif.data = d; tif.stall = s; pop = p;
        #1;
        exp_ready = !s && (q.size() != DEPTH);
        chk("ready", {31'd0, tif.ready}, {31'd0, exp_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("count", 32'(count), 32'(q.size()));
        push   = v && exp_ready;
        popeff = p && (q.size() != 0);
        if (popeff) begin
            chk("out_data", 32'(out_data), 32'(q[0]));
            void'(q.pop_front());
        end
        if (!m_hold) begin
            if (v && !exp_ready) begin m_hold = 1; m_held = d; end
        end else begin
            if (push) m_hold = 0;
            else if (v && d == m_held) m_hold = 1;
            else begin m_err = 1; m_hold = 0; end
        end
        if (push) begin
            q.push_back(d);
            m_total = (m_total + 1) % (1 << CNT_W);
        end
        @(posedge clk); #1;
        chk("rx_total", 32'(rx_total), 32'(m_total));
        chk("proto_err", {31'd0, proto_err}, {31'd0, m_err});
        chk("count_post", 32'(count), 32'(q.size()));
        $display("cyc v=%0b d=%02h s=%0b p=%0b push=%0b pop=%0b cnt=%0d tot=%0d err=%0b",
                 v, d, s, p, push, popeff, count, rx_total, proto_err);
    endtask

    initial begin
        do_reset();

        // Two transfers with no pop.
        cycle(1, 8'hAB, 0, 0);
        cycle(1, 8'hCD, 0, 0);
        tif.valid = 0; #1;
        chk("seq1_count", 32'(count), 32'd2);
        chk("seq1_head", 32'(out_data), 32'hAB);
        chk("seq1_total", 32'(rx_total), 32'd2);
        chk("seq1_err", {31'd0, proto_err}, 32'd0);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);

        // Fill the FIFO, hold 05 against a full FIFO, then pop once to let 05 in.
        for (int i = 1; i <= 4; i++) cycle(1, data_t'(i), 0, 0);
        cycle(1, 8'h05, 0, 0);
        cycle(1, 8'h05, 0, 1);
        cycle(1, 8'h05, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0, 1);

        // Stall for 3 cycles with stable data: one clean transfer.
        for (int i = 0; i < 3; i++) cycle(1, 8'h5A, 1, 0);
        cycle(1, 8'h5A, 0, 0);
        cycle(0, 8'h00, 0, 1);
        chk("stall_err", {31'd0, proto_err}, 32'd0);

        // Data changes while stalled: sticky error.
        cycle(1, 8'h11, 1, 0);
        cycle(1, 8'h22, 1, 0);
        chk("change_err", {31'd0, proto_err}, 32'd1);
        cycle(1, 8'h22, 0, 0);
        cycle(1, 8'h33, 0, 1);
        cycle(0, 8'h00, 0, 1);
        chk("sticky_err", {31'd0, proto_err}, 32'd1);

        // Continuous push and pop at count=1, then pops on empty.
        do_reset();
        cycle(1, 8'h40, 0, 0);
        for (int i = 1; i <= 10; i++) cycle(1, data_t'(8'h40 + i), 0, 1);
        chk("pp_count", 32'(count), 32'd1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        chk("empty_count", 32'(count), 32'd0);

        // rx_total wrap with CNT_W=4, then reset with entries buffered.
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1, data_t'(8'h80 + i), 0, 1);
        chk("wrap_total", 32'(rx_total), 32'd1);
        cycle(0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, data_t'(8'hC0 + i), 0, 0);
        chk("pre_rst_count", 32'(count), 32'd3);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rx_responder
